// File: rtl/rr_mux_arbiter_if.sv
// Request/operand bus and downstream valid/ready handshake of the round-robin mux arbiter.
// master = operand sources and downstream consumer, slave = the arbiter.
interface rr_mux_arbiter_if #(
    parameter int DW = 32
);
    logic [3:0]    req;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] data3;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [1:0]    sel;
    logic [3:0]    gnt;
    logic          busy;
    logic          timeout_err;

    modport master (
        output req, data0, data1, data2, data3, out_ready,
        input  out_data, out_valid, sel, gnt, busy, timeout_err
    );

    modport slave (
        input  req, data0, data1, data2, data3, out_ready,
        output out_data, out_valid, sel, gnt, busy, timeout_err
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 operand mux with a registered valid/ready output.
// Optional HOLD abort after TIMEOUT stalled cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst_n,
    rr_mux_arbiter_if.slave bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
        $error("rr_mux_arbiter: TIMEOUT must lie in 1..255");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [1:0]    r_last;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_data;
    logic [3:0]    r_gnt;
    logic          r_timeoutErr;

    logic [3:0]    w_eff;
    logic          w_found;
    logic [1:0]    w_winner;
    logic [DW-1:0] w_srcData;
    logic          w_start;
    logic          w_accept;
    logic          w_abort;

    // A source whose grant is currently pulsing has already been served.
    assign w_eff    = bus.req & ~r_gnt;
    assign w_start  = (r_state == IDLE) && w_found;
    assign w_accept = (r_state == HOLD) && bus.out_ready;

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_eff[2'(r_last + 2'(k))]) begin
                w_found  = 1'b1;
                w_winner = 2'(r_last + 2'(k));
            end
        end
    end

    always_comb begin
        case (w_winner)
            2'd0:    w_srcData = bus.data0;
            2'd1:    w_srcData = bus.data1;
            2'd2:    w_srcData = bus.data2;
            default: w_srcData = bus.data3;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (w_start) begin
            r_count <= 8'd0;
        end else if ((r_state == HOLD) && !bus.out_ready) begin
            r_count <= r_count + 8'd1;
        end
    end

    // The stalled cycle that would bring the count to TIMEOUT is the abort edge.
    assign w_abort = (r_state == HOLD) && !bus.out_ready && (r_count == TO_LAST);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found) w_nextState = HOLD;
            HOLD:    if (w_accept || w_abort) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid   = (r_state == HOLD);
        bus.busy        = (r_state == HOLD);
        bus.out_data    = r_data;
        bus.sel         = r_sel;
        bus.gnt         = r_gnt;
        bus.timeout_err = r_timeoutErr;
    end

    // Operand is sampled only on the grant-in edge; sel keeps the last winner afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last       <= 2'd3;
            r_sel        <= 2'd0;
            r_data       <= '0;
            r_gnt        <= 4'd0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_gnt        <= 4'd0;
            r_timeoutErr <= w_abort;
            if (w_start) begin
                r_sel  <= w_winner;
                r_data <= w_srcData;
            end
            if (w_accept) begin
                r_gnt  <= 4'b0001 << r_sel;
                r_last <= r_sel;
            end
            if (w_abort) begin
                r_last <= r_sel;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter checked against a transaction-level round-robin model.
// Define ARB_TIMEOUT_EN for both bench and RTL to exercise the HOLD abort path.
module tb_rr_mux_arbiter;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.DW(DW)) bus();

    rr_mux_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit            mHold;
    int            mLast;
    int            mSel;
    int            mCount;
    logic [DW-1:0] mData;
    logic [3:0]    mGnt;
    bit            mTerr;

    logic [3:0] autoMask;
    bit         reqRandom;
    int         readyMode;
    bit         dataRandom;
    int         grantLog[$];
    int         expQ[$];
    int         timeoutCount;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mHold  = 1'b0;
        mLast  = 3;
        mSel   = 0;
        mCount = 0;
        mData  = '0;
        mGnt   = 4'd0;
        mTerr  = 1'b0;
    endtask

    function automatic logic [DW-1:0] srcData(input int i);
        case (i)
            0:       return bus.data0;
            1:       return bus.data1;
            2:       return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    // One transaction-level step of the arbiter for the upcoming rising edge.
    task automatic modelStep();
        logic [3:0] eff;
        int w;
        eff   = bus.req & ~mGnt;
        mGnt  = 4'd0;
        mTerr = 1'b0;
        if (!mHold) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && eff[(mLast + k) % 4]) w = (mLast + k) % 4;
            if (w >= 0) begin
                mHold  = 1'b1;
                mSel   = w;
                mData  = srcData(w);
                mCount = 0;
            end
        end else if (bus.out_ready) begin
            mGnt  = 4'(1 << mSel);
            mLast = mSel;
            mHold = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (mCount + 1 == TIMEOUT) begin
            mTerr = 1'b1;
            mLast = mSel;
            mHold = 1'b0;
        end else begin
            mCount++;
        end
`endif
    endtask

    task automatic checkAll();
        checkOutput("out_valid",   bus.out_valid,   mHold);
        checkOutput("busy",        bus.busy,        mHold);
        checkOutput("sel",         bus.sel,         mSel);
        checkOutput("out_data",    bus.out_data,    mData);
        checkOutput("gnt",         bus.gnt,         mGnt);
        checkOutput("timeout_err", bus.timeout_err, mTerr);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_out_valid",   bus.out_valid,   0);
        checkOutput("rst_busy",        bus.busy,        0);
        checkOutput("rst_sel",         bus.sel,         0);
        checkOutput("rst_out_data",    bus.out_data,    0);
        checkOutput("rst_gnt",         bus.gnt,         0);
        checkOutput("rst_timeout_err", bus.timeout_err, 0);
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_len"}, grantLog.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            checkOutput(tag, (i < grantLog.size()) ? grantLog[i] : -1, expQ[i]);
        grantLog.delete();
    endtask

    // Requesters hold req until they see gnt; persistent ones re-raise afterwards.
    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) begin
            if (bus.gnt[i])
                bus.req[i] = 1'b0;
            else if (autoMask[i] && (!reqRandom || $urandom_range(0, 3) == 0))
                bus.req[i] = 1'b1;
        end
        case (readyMode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (dataRandom) begin
            bus.data0 = $urandom;
            bus.data1 = $urandom;
            bus.data2 = $urandom;
            bus.data3 = $urandom;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkAll();
            for (int i = 0; i < 4; i++)
                if (bus.gnt[i]) grantLog.push_back(i);
            if (bus.timeout_err) timeoutCount++;
            applyStimulus();
        end
    endtask

    task automatic resetPulse();
        #2 rst_n = 1'b0;
        #1 checkResetOutputs();
        modelReset();
        bus.req = 4'd0;
        grantLog.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req       = 4'd0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.data2     = '0;
        bus.data3     = '0;
        bus.out_ready = 1'b0;
        autoMask      = 4'd0;
        reqRandom     = 1'b0;
        readyMode     = 1;
        dataRandom    = 1'b0;
        timeoutCount  = 0;
        modelReset();

        #1 rst_n = 1'b0;
        #2 checkResetOutputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from source 0.
        bus.req       = 4'b0001;
        bus.data0     = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        runCycles(3);
        expQ = {0};
        checkLog("single_grant");

        // Full round-robin rotation from reset with immediate re-requests.
        resetPulse();
        autoMask = 4'b1111;
        bus.req  = 4'b1111;
        runCycles(10);
        expQ = {0, 1, 2, 3, 0};
        checkLog("rotation");
        autoMask = 4'd0;
        bus.req  = 4'd0;
        runCycles(4);
        grantLog.delete();

        // Pointer wrap past source 3.
        bus.req = 4'b0100;
        runCycles(3);
        bus.req = 4'b0101;
        runCycles(6);
        expQ = {2, 0, 2};
        checkLog("wrap");

        // Downstream stall while source data keeps changing.
        bus.req       = 4'b0010;
        readyMode     = 0;
        bus.out_ready = 1'b0;
        dataRandom    = 1'b1;
        runCycles(6);
        readyMode  = 1;
        bus.out_ready = 1'b1;
        dataRandom = 1'b0;
        runCycles(3);
        expQ = {1};
        checkLog("stall");

        // Reset in the middle of HOLD, then normal service.
        bus.req       = 4'b0010;
        readyMode     = 0;
        bus.out_ready = 1'b0;
        runCycles(3);
        resetPulse();
        bus.req       = 4'b0010;
        bus.data1     = 32'h1234_5678;
        readyMode     = 1;
        bus.out_ready = 1'b1;
        runCycles(3);
        expQ = {1};
        checkLog("after_reset");

`ifdef ARB_TIMEOUT_EN
        // Abort of source 0, then source 1 served, then source 0 re-served.
        bus.req       = 4'b0011;
        readyMode     = 0;
        bus.out_ready = 1'b0;
        runCycles(20);
        checkOutput("timeout_pulses", timeoutCount, 1);
        readyMode     = 1;
        bus.out_ready = 1'b1;
        runCycles(6);
        expQ = {1, 0};
        checkLog("timeout_reserve");

        // Acceptance in the final allowed HOLD cycle beats the abort.
        bus.req       = 4'b0100;
        readyMode     = 0;
        bus.out_ready = 1'b0;
        runCycles(15);
        readyMode     = 1;
        bus.out_ready = 1'b1;
        runCycles(3);
        checkOutput("timeout_pulses_late_accept", timeoutCount, 1);
        expQ = {2};
        checkLog("late_accept");
`endif

        // Randomized traffic.
        reqRandom  = 1'b1;
        dataRandom = 1'b1;
        readyMode  = 2;
        for (int blk = 0; blk < 6; blk++) begin
            autoMask = 4'($urandom_range(1, 15));
            runCycles(60);
        end
        autoMask  = 4'd0;
        readyMode = 1;
        runCycles(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
